// File: rtl/r4_merge_scheduler.sv
// Radix-4 merge sequencer: aligns four sub-FFT frames, streams them into the twiddle/butterfly path and counts merged results.
// Optional skew watchdog on flag alignment is enabled by defining R4_MERGE_SCHED_SKEW_CHECK_EN.
module r4_merge_scheduler #(
    parameter int SIZE_BUFFER = 4,
    parameter int PIPE_LAT    = 6,
    parameter int SKEW_MAX    = 15
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_flag_complete_0,
    input  logic                   i_flag_complete_1,
    input  logic                   i_flag_complete_2,
    input  logic                   i_flag_complete_3,
    input  logic                   i_dataComplete,
    output logic                   o_resiveFrom_0,
    output logic                   o_resiveFrom_1,
    output logic                   o_resiveFrom_2,
    output logic                   o_resiveFrom_3,
    output logic                   o_en_mult,
    output logic [15:0]            o_phi,
    output logic [SIZE_BUFFER-1:0] o_counterMultData2,
    output logic                   o_mutDone,
    output logic                   o_busy,
    output logic                   o_abort,
    output logic                   o_skew_err,
    output logic [1:0]             o_state_dbg
);

    // Handshake: a read strobe means the sub-FFT buffers present one sample per cycle with no
    // back-pressure; i_dataComplete is a one-cycle valid that is always accepted in STREAM/DRAIN.
    localparam int WD_W = $clog2(2 * PIPE_LAT + 1);
    localparam logic [SIZE_BUFFER-1:0] LAST_IDX = '1;
    // Abort is registered, so it lands 2*PIPE_LAT cycles after the last valid.
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(2 * PIPE_LAT - 2);

    typedef enum logic [1:0] {S_REARM, S_ARMED, S_STREAM, S_DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [SIZE_BUFFER-1:0] rd_cnt_q, rd_cnt_d;
    logic [SIZE_BUFFER-1:0] out_cnt_q, out_cnt_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic [SIZE_BUFFER-1:0] phi_q;
    logic                   en_mult_q;
    logic                   done_q, done_d;
    logic                   abort_q, abort_d;
    logic                   busy_q, busy_d;
    logic [3:0]             flags;
    logic                   all_high, any_high, strobe;

`ifdef R4_MERGE_SCHED_SKEW_CHECK_EN
    localparam int SK_W = $clog2(SKEW_MAX + 1);
    logic [SK_W-1:0] skew_q, skew_d;
    logic            skerr_q, skerr_d;
`endif

    assign flags    = {i_flag_complete_3, i_flag_complete_2, i_flag_complete_1, i_flag_complete_0};
    assign all_high = &flags;
    assign any_high = |flags;
    assign strobe   = (state_q == S_STREAM);

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        out_cnt_d = out_cnt_q;
        wd_d      = wd_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
`ifdef R4_MERGE_SCHED_SKEW_CHECK_EN
        skew_d    = skew_q;
        skerr_d   = 1'b0;
`endif
        case (state_q)
            S_REARM: begin
                out_cnt_d = '0;
                if (!any_high) state_d = S_ARMED;
            end
            S_ARMED: begin
                out_cnt_d = '0;
                if (all_high) begin
                    state_d  = S_STREAM;
                    rd_cnt_d = '0;
                    wd_d     = '0;
`ifdef R4_MERGE_SCHED_SKEW_CHECK_EN
                    skew_d   = '0;
                end else if (any_high) begin
                    if (skew_q == SK_W'(SKEW_MAX - 1)) begin
                        skerr_d = 1'b1;
                        skew_d  = '0;
                        state_d = S_REARM;
                    end else begin
                        skew_d = skew_q + 1'b1;
                    end
                end else begin
                    skew_d = '0;
`endif
                end
            end
            default: begin
                if (i_dataComplete) out_cnt_d = out_cnt_q + 1'b1;
                if (state_q == S_STREAM) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    wd_d     = '0;
                    if (rd_cnt_q == LAST_IDX) state_d = S_DRAIN;
                end else begin
                    wd_d = i_dataComplete ? '0 : wd_q + 1'b1;
                end
                // Final valid takes priority over any abort cause in the same cycle.
                if (i_dataComplete && out_cnt_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = S_REARM;
                end else if (state_q == S_STREAM && !all_high) begin
                    abort_d   = 1'b1;
                    out_cnt_d = '0;
                    state_d   = S_REARM;
                end else if (state_q == S_DRAIN && !i_dataComplete && wd_q == WD_LIMIT) begin
                    abort_d   = 1'b1;
                    out_cnt_d = '0;
                    state_d   = S_REARM;
                end
            end
        endcase
        busy_d = (state_d == S_STREAM) || (state_d == S_DRAIN) || done_d || abort_d;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_REARM;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
            wd_q      <= '0;
            phi_q     <= '0;
            en_mult_q <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            out_cnt_q <= out_cnt_d;
            wd_q      <= wd_d;
            phi_q     <= strobe ? rd_cnt_q : '0;
            en_mult_q <= strobe;
            done_q    <= done_d;
            abort_q   <= abort_d;
            busy_q    <= busy_d;
        end
    end

`ifdef R4_MERGE_SCHED_SKEW_CHECK_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            skew_q  <= '0;
            skerr_q <= 1'b0;
        end else begin
            skew_q  <= skew_d;
            skerr_q <= skerr_d;
        end
    end
    assign o_skew_err = skerr_q;
`else
    // SKEW_MAX stays referenced so both builds share one parameter list.
    assign o_skew_err = 1'b0 && (SKEW_MAX > 0);
`endif

    assign o_resiveFrom_0     = strobe;
    assign o_resiveFrom_1     = strobe;
    assign o_resiveFrom_2     = strobe;
    assign o_resiveFrom_3     = strobe;
    assign o_en_mult          = en_mult_q;
    assign o_phi              = 16'(phi_q);
    assign o_counterMultData2 = out_cnt_q;
    assign o_mutDone          = done_q;
    assign o_abort            = abort_q;
    assign o_busy             = busy_q;
    assign o_state_dbg        = state_q;

endmodule

// File: doc/r4_merge_scheduler.md
# r4_merge_scheduler

Sequencer for the radix-4 merge stage of the split FFT. It waits until all four sub-FFT engines report a complete frame, then streams their outputs in lockstep into the twiddle multiplier and x4 butterfly. It drives the twiddle phase index and counts the merged results, and it ends the frame with a one-cycle done pulse that releases the sub-FFTs. It sits between the four sub-FFT engines and the merge datapath; that datapath has no sequencing logic of its own.

## Interface
- SIZE_BUFFER, default 4: log2 of the points per sub-FFT branch; N = 1<<SIZE_BUFFER reads per frame.
- PIPE_LAT, default 6: cycles from the multiplier enable to the butterfly's output valid; used only by the drain watchdog.
- SKEW_MAX, default 15: maximum cycles between the first and the last sub-FFT complete flag.
- i_clk  in  1  clock, all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_flag_complete_0..3  in  1 each  level; sub-FFT k holds an unread complete frame.
- i_dataComplete  in  1  merged-output valid from the butterfly.
- o_resiveFrom_0..3  out  1 each  read strobe to sub-FFT k output buffer; all four identical.
- o_en_mult  out  1  multiplier enable; data from the sub-FFTs is valid on this cycle.
- o_phi  out  16  twiddle index aligned with o_en_mult, zero-extended from SIZE_BUFFER bits.
- o_counterMultData2  out  SIZE_BUFFER  index of the current merged output.
- o_mutDone  out  1  one-cycle end-of-frame pulse.
- o_busy  out  1  high in STREAM and DRAIN.
- o_abort  out  1  one-cycle pulse on a frame aborted by flag loss or drain timeout.
- o_skew_err  out  1  one-cycle pulse on a skew violation.

## Operation
- State REARM: wait until all four flags are low, then go to ARMED. Stale flags left over from the previous frame never start a new frame.
- State ARMED: when all four flags are high in the same cycle, go to STREAM and clear the read counter rd_cnt.
  - If any flag is high while the others are not, a skew counter increments.
  - If that counter reaches SKEW_MAX, pulse o_skew_err and go to REARM.
  - The skew counter clears when no flag is high.
- State STREAM: assert o_resiveFrom_k for exactly N consecutive cycles, incrementing rd_cnt each cycle. Go to DRAIN after the strobe with rd_cnt = N-1.
  - Any flag low during STREAM: pulse o_abort, drop the strobes in the next cycle, go to REARM.
- Pipeline registers:
  - o_en_mult is the registered copy of the read strobe.
  - o_phi is the registered copy of rd_cnt, so the first enabled sample has phi = 0 and the last has phi = N-1.
- Output counting (STREAM and DRAIN): each cycle with i_dataComplete high increments o_counterMultData2. When i_dataComplete arrives with o_counterMultData2 = N-1:
  - pulse o_mutDone,
  - wrap o_counterMultData2 to 0,
  - go to REARM.
- Drain watchdog (DRAIN): counts cycles without i_dataComplete. At 2*PIPE_LAT it pulses o_abort, clears o_counterMultData2 and goes to REARM.
- o_mutDone and o_abort are never high together. If a flag drops in the same cycle as the final valid, the final valid wins and o_mutDone is pulsed.
- i_dataComplete outside STREAM and DRAIN is ignored and the counter is held at 0.

## Timing
- Reset values: all outputs 0; state REARM; all counters 0.
- Reset is asynchronous, so assertion clears state and outputs immediately, including mid-STREAM. After release the block starts in REARM, so a frame interrupted by reset is never resumed.
- Cycle t is the first cycle all flags are high in ARMED:
  - strobes high during t+1..t+N;
  - o_en_mult high during t+2..t+N+1;
  - o_phi = k at cycle t+2+k.
- Minimum frame length is N + PIPE_LAT + 2 cycles from flag alignment to o_mutDone.
- o_busy is registered: it rises at t+1 and falls in the cycle after o_mutDone or o_abort.
- Back-to-back frames need at least one cycle with all flags low between them (REARM).

## Configuration
- Macro R4_MERGE_SCHED_SKEW_CHECK_EN.
- Defined: the skew counter and o_skew_err are implemented as described above.
- Undefined: no skew counter, o_skew_err is tied to 0, and ARMED waits indefinitely for alignment.

## Test plan
- Aligned frame, SIZE_BUFFER=4, PIPE_LAT=6: all flags rise at cycle 10, model returns 16 valids after 6 cycles -> strobes at cycles 11..26, phi 0..15 at 12..27, o_mutDone at the 16th valid, counter back at 0.
- Skewed flags with the macro defined: flag 0 at cycle 5, flags 1..3 never -> o_skew_err at cycle 20, state REARM, no strobes.
- Flag 2 drops at the 8th strobe -> o_abort next cycle, strobes low, no o_mutDone; after all flags go low and rise again, a clean frame completes.
- Drain timeout: model stops after 10 valids -> o_abort 12 cycles after the last valid, counter 0.
- Asynchronous reset mid-STREAM at phi = 5 -> all outputs 0 immediately; flags held high after release cause no frame until they toggle low then high.
- Stale flags: flags still high after o_mutDone -> no restart; restart only after all flags are low.
